// File: rtl/servo_pkg.sv
// Shared constants and types for the servo sweep controller and its frame timer.
package servo_pkg;

  localparam int DEF_FRAME_US  = 20000;
  localparam int DEF_MIN_US    = 1000;
  localparam int DEF_MAX_US    = 2000;
  localparam int DEF_CENTER_US = 1500;

  // Pulse widths and microsecond counts are carried as 16-bit unsigned values.
  typedef logic [15:0] pw_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

endpackage

// File: rtl/servo_frame_timer.sv
// Frame timebase: divides CLK down to a 1 us tick, counts microseconds within a
// frame and strobes frame_tick for one cycle whenever the count wraps to zero.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int CLK_F    = 50,
  parameter int FRAME_US = DEF_FRAME_US
) (
  input  logic CLK,
  input  logic RST_N,
  output pw_t  us_cnt,
  output logic frame_tick
);

  localparam int PW = (CLK_F > 1) ? $clog2(CLK_F) : 1;

  logic [PW-1:0] presc_q;

  // Prescaler, microsecond counter and frame boundary strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q    <= '0;
      us_cnt     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (presc_q == PW'(CLK_F - 1)) begin
        presc_q <= '0;
        if (us_cnt == 16'(FRAME_US - 1)) begin
          us_cnt     <= '0;
          frame_tick <= 1'b1;
        end else begin
          us_cnt <= us_cnt + 16'd1;
        end
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/servo_sweep_ctrl.sv
// Multi-channel servo position scheduler. Commands set a clamped target and a
// per-frame slew limit per channel; once per frame a single shared slew ALU
// walks all channels, one per cycle, moving pulse_len toward its target.
module servo_sweep_ctrl
  import servo_pkg::*;
#(
  parameter int CLK_F     = 50,
  parameter int NUM_CH    = 4,
  parameter int FRAME_US  = DEF_FRAME_US,
  parameter int MIN_US    = DEF_MIN_US,
  parameter int MAX_US    = DEF_MAX_US,
  parameter int CENTER_US = DEF_CENTER_US,
  localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CW-1:0]        cmd_chan,
  input  logic [15:0]          cmd_target,
  input  logic [7:0]           cmd_step,
  output logic [16*NUM_CH-1:0] pulse_len,
  output logic [NUM_CH-1:0]    moving,
  output logic                 frame_tick
);

  // Saturate a requested pulse length into the legal servo range.
  function automatic pw_t clamp_us(input pw_t v);
    if (v < 16'(MIN_US))      return 16'(MIN_US);
    else if (v > 16'(MAX_US)) return 16'(MAX_US);
    else                      return v;
  endfunction

  // One slew step: move cur toward tgt by at most stp, landing exactly on tgt
  // when it is within reach. stp == 0 means no limit.
  function automatic pw_t slew(input pw_t cur, input pw_t tgt, input logic [7:0] stp);
    logic signed [16:0] d;
    logic        [16:0] mag;
    d   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag = d[16] ? $unsigned(-d) : $unsigned(d);
    if (stp == 8'd0 || mag <= {9'd0, stp}) return tgt;
    else if (d[16])                        return cur - {8'd0, stp};
    else                                   return cur + {8'd0, stp};
  endfunction

  pw_t           us_cnt;
  logic          sweep_start;
  state_t        state_q, state_d;
  logic [CW-1:0] idx_q;

  pw_t           target_q [NUM_CH];
  logic [7:0]    step_q   [NUM_CH];
  pw_t           pulse_q  [NUM_CH];
  logic [NUM_CH-1:0] moving_q;

  pw_t           tgt_clamped;
  pw_t           slew_next;
  logic          cmd_fire;
  logic          chan_ok;

  servo_frame_timer #(
    .CLK_F    (CLK_F),
    .FRAME_US (FRAME_US)
  ) u_timer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .us_cnt     (us_cnt),
    .frame_tick (frame_tick)
  );

  // The strobe coincides with the counter sitting at zero; qualify on both.
  assign sweep_start = frame_tick && (us_cnt == '0);

  assign cmd_ready   = (state_q == ST_IDLE);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign chan_ok     = (int'(cmd_chan) < NUM_CH);
  assign tgt_clamped = clamp_us(cmd_target);

  // Shared slew ALU, fed by whichever channel the sweep index points at.
  always_comb begin
    slew_next = slew(pulse_q[idx_q], target_q[idx_q], step_q[idx_q]);
  end

  // FSM state register and sweep channel index.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= (state_q == ST_UPDATE) ? idx_q + CW'(1) : '0;
    end
  end

  // Next-state: a frame boundary starts a sweep of exactly NUM_CH cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (sweep_start) state_d = ST_UPDATE;
      ST_UPDATE: if (idx_q == CW'(NUM_CH - 1)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Per-channel register file: command writes in IDLE, slew writes in UPDATE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        target_q[ch] <= 16'(CENTER_US);
        step_q[ch]   <= 8'd0;
        pulse_q[ch]  <= 16'(CENTER_US);
      end
      moving_q <= '0;
    end else begin
      if (cmd_fire && chan_ok) begin
        target_q[cmd_chan] <= tgt_clamped;
        step_q[cmd_chan]   <= cmd_step;
        if (cmd_step == 8'd0) begin
          pulse_q[cmd_chan]  <= tgt_clamped;
          moving_q[cmd_chan] <= 1'b0;
        end else begin
          moving_q[cmd_chan] <= (pulse_q[cmd_chan] != tgt_clamped);
        end
      end
      if (state_q == ST_UPDATE) begin
        pulse_q[idx_q]  <= slew_next;
        moving_q[idx_q] <= (slew_next != target_q[idx_q]);
      end
    end
  end

  // Flatten the per-channel positions onto the output bus.
  always_comb begin
    pulse_len = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pulse_len[16*ch +: 16] = pulse_q[ch];
    end
  end

  assign moving = moving_q;

endmodule
